// File: rtl/round_sequencer.sv
// Round/turn/score sequencer for SpyMangler: arms P1, clears and times P2, tallies score.
// Optional ROUND_SEQUENCER_SUDDEN_DEATH_EN: tied games continue with extra rounds.
module round_sequencer #(
  parameter int unsigned TURN_SECONDS = 30,
  parameter int unsigned NUM_ROUNDS   = 3,
  parameter int unsigned RESULT_TICKS = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_done,
  input  logic       p2_done,
  input  logic       p2_correct,
  output logic       p1_enable,
  output logic       p2_enable,
  output logic       p2_clear_n,
  output logic [2:0] phase,
  output logic [7:0] time_left,
  output logic [3:0] round,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StP1Turn   = 3'd1,
    StP2Clear  = 3'd2,
    StP2Turn   = 3'd3,
    StRoundEnd = 3'd4,
    StGameOver = 3'd5
  } state_e;

  localparam logic [7:0] TurnLoad  = 8'(TURN_SECONDS);
  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
  localparam logic [3:0] HoldLoad  = 4'(RESULT_TICKS);

  state_e     r_state,     w_state_next;
  logic [7:0] r_time_left, w_time_left_next;
  logic [3:0] r_round,     w_round_next;
  logic [3:0] r_score1,    w_score1_next;
  logic [3:0] r_score2,    w_score2_next;
  logic [1:0] r_winner,    w_winner_next;
  logic [3:0] r_hold,      w_hold_next;

  logic r_start_prev, r_p1_prev, r_p2_prev;
  logic w_start_edge, w_p1_edge, w_p2_edge;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [1:0] judge(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) return 2'b01;
    if (s2 > s1) return 2'b10;
    return 2'b11;
  endfunction

  // Edge registers reset high so a key held through reset never fires.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_start_prev <= 1'b1;
      r_p1_prev    <= 1'b1;
      r_p2_prev    <= 1'b1;
    end else begin
      r_start_prev <= start;
      r_p1_prev    <= p1_done;
      r_p2_prev    <= p2_done;
    end
  end

  assign w_start_edge = start & ~r_start_prev;
  assign w_p1_edge    = p1_done & ~r_p1_prev;
  assign w_p2_edge    = p2_done & ~r_p2_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_time_left <= 8'd0;
      r_round     <= 4'd0;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_winner    <= 2'b00;
      r_hold      <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_time_left <= w_time_left_next;
      r_round     <= w_round_next;
      r_score1    <= w_score1_next;
      r_score2    <= w_score2_next;
      r_winner    <= w_winner_next;
      r_hold      <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_time_left_next = r_time_left;
    w_round_next     = r_round;
    w_score1_next    = r_score1;
    w_score2_next    = r_score2;
    w_winner_next    = r_winner;
    w_hold_next      = r_hold;

    case (r_state)
      StIdle, StGameOver: begin
        if (w_start_edge) begin
          w_round_next     = 4'd1;
          w_score1_next    = 4'd0;
          w_score2_next    = 4'd0;
          w_winner_next    = 2'b00;
          w_time_left_next = TurnLoad;
          w_state_next     = StP1Turn;
        end
      end

      StP1Turn: begin
        // A done edge wins over a simultaneous expiring tick.
        if (w_p1_edge) begin
          w_state_next = StP2Clear;
        end else if (tick) begin
          if (r_time_left <= 8'd1) begin
            w_time_left_next = 8'd0;
            w_score2_next    = sat_inc(r_score2);
            w_hold_next      = HoldLoad;
            w_state_next     = StRoundEnd;
          end else begin
            w_time_left_next = r_time_left - 8'd1;
          end
        end
      end

      StP2Clear: begin
        w_time_left_next = TurnLoad;
        w_state_next     = StP2Turn;
      end

      StP2Turn: begin
        if (w_p2_edge) begin
          if (p2_correct) w_score2_next = sat_inc(r_score2);
          else            w_score1_next = sat_inc(r_score1);
          w_hold_next  = HoldLoad;
          w_state_next = StRoundEnd;
        end else if (tick) begin
          if (r_time_left <= 8'd1) begin
            w_time_left_next = 8'd0;
            w_score1_next    = sat_inc(r_score1);
            w_hold_next      = HoldLoad;
            w_state_next     = StRoundEnd;
          end else begin
            w_time_left_next = r_time_left - 8'd1;
          end
        end
      end

      StRoundEnd: begin
        if (tick) begin
          if (r_hold <= 4'd1) begin
            w_hold_next = 4'd0;
            if (r_round >= LastRound) begin
`ifdef ROUND_SEQUENCER_SUDDEN_DEATH_EN
              if (r_score1 == r_score2) begin
                w_round_next     = sat_inc(r_round);
                w_time_left_next = TurnLoad;
                w_state_next     = StP1Turn;
              end else begin
                w_winner_next = judge(r_score1, r_score2);
                w_state_next  = StGameOver;
              end
`else
              w_winner_next = judge(r_score1, r_score2);
              w_state_next  = StGameOver;
`endif
            end else begin
              w_round_next     = r_round + 4'd1;
              w_time_left_next = TurnLoad;
              w_state_next     = StP1Turn;
            end
          end else begin
            w_hold_next = r_hold - 4'd1;
          end
        end
      end

      default: w_state_next = StIdle;
    endcase
  end

  assign p1_enable  = (r_state == StP1Turn);
  assign p2_enable  = (r_state == StP2Turn);
  assign p2_clear_n = (r_state != StP2Clear);
  assign phase      = r_state;
  assign time_left  = r_time_left;
  assign round      = r_round;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign winner     = r_winner;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer (default build and a 2-round variant).
module tb_round_sequencer;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic tick = 1'b0, start = 1'b0, p1_done = 1'b0, p2_done = 1'b0, p2_correct = 1'b0;

  logic       p1_enable, p2_enable, p2_clear_n;
  logic [2:0] phase;
  logic [7:0] time_left;
  logic [3:0] round, score1, score2;
  logic [1:0] winner;

  logic       d2_p1_enable, d2_p2_enable, d2_p2_clear_n;
  logic [2:0] d2_phase;
  logic [7:0] d2_time_left;
  logic [3:0] d2_round, d2_score1, d2_score2;
  logic [1:0] d2_winner;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] RstVec = {1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0, 2'd0};

  round_sequencer u_dut (
    .clock(clock), .resetn(resetn), .tick(tick), .start(start), .p1_done(p1_done),
    .p2_done(p2_done), .p2_correct(p2_correct), .p1_enable(p1_enable),
    .p2_enable(p2_enable), .p2_clear_n(p2_clear_n), .phase(phase), .time_left(time_left),
    .round(round), .score1(score1), .score2(score2), .winner(winner)
  );

  round_sequencer #(.TURN_SECONDS(4), .NUM_ROUNDS(2), .RESULT_TICKS(1)) u_dut2 (
    .clock(clock), .resetn(resetn), .tick(tick), .start(start), .p1_done(p1_done),
    .p2_done(p2_done), .p2_correct(p2_correct), .p1_enable(d2_p1_enable),
    .p2_enable(d2_p2_enable), .p2_clear_n(d2_p2_clear_n), .phase(d2_phase),
    .time_left(d2_time_left), .round(d2_round), .score1(d2_score1), .score2(d2_score2),
    .winner(d2_winner)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_tick(input int n);
    repeat (n) begin
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
    end
  endtask

  task automatic press_start;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Leaves the DUT in P2_CLEAR.
  task automatic press_p1;
    @(negedge clock); p1_done = 1'b1;
    @(negedge clock); p1_done = 1'b0;
  endtask

  // Leaves the DUT in ROUND_END.
  task automatic submit_p2(input logic ok);
    @(negedge clock); p2_correct = ok; p2_done = 1'b1;
    @(negedge clock); p2_done = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    resetn = 1'b0; tick = 1'b0; start = 1'b0; p1_done = 1'b0; p2_done = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    @(negedge clock);
    resetn = 1'b0; start = 1'b1; p1_done = 1'b1; p2_done = 1'b1;
    #1;
    checks++;
    if ({p1_enable, p2_enable, p2_clear_n, phase, time_left, round, score1, score2, winner}
        !== RstVec) begin
      errors++;
      $display("FAIL reset_outputs got %h expected %h",
               {p1_enable, p2_enable, p2_clear_n, phase, time_left, round, score1, score2,
                winner}, RstVec);
    end
    checks++;
    if ({d2_p1_enable, d2_p2_enable, d2_p2_clear_n, d2_phase, d2_time_left, d2_round,
         d2_score1, d2_score2, d2_winner} !== RstVec) begin
      errors++;
      $display("FAIL reset_outputs_dut2 got %h expected %h",
               {d2_p1_enable, d2_p2_enable, d2_p2_clear_n, d2_phase, d2_time_left, d2_round,
                d2_score1, d2_score2, d2_winner}, RstVec);
    end
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL held_start_through_reset phase got %0d expected 0", phase);
    end
    start = 1'b0; p1_done = 1'b0; p2_done = 1'b0;
    cyc(1);
  endtask

  task automatic test_start;
    press_start;
    checks++;
    if ({phase, round, time_left, score1, score2, p1_enable, p2_enable}
        !== {3'd1, 4'd1, 8'd30, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_game got ph=%0d rnd=%0d t=%0d s=%0d/%0d en=%b%b expected 1 1 30 0/0 10",
               phase, round, time_left, score1, score2, p1_enable, p2_enable);
    end
  endtask

  task automatic test_round_correct;
    pulse_tick(1);
    checks++;
    if (time_left !== 8'd29) begin
      errors++;
      $display("FAIL p1_tick_decrement got %0d expected 29", time_left);
    end
    press_p1;
    checks++;
    if ({phase, p2_clear_n} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL p2_clear_pulse got ph=%0d clr_n=%b expected 2 0", phase, p2_clear_n);
    end
    cyc(1);
    checks++;
    if ({phase, p2_clear_n, p2_enable, p1_enable, time_left}
        !== {3'd3, 1'b1, 1'b1, 1'b0, 8'd30}) begin
      errors++;
      $display("FAIL p2_turn_entry got ph=%0d clr_n=%b en2=%b en1=%b t=%0d expected 3 1 1 0 30",
               phase, p2_clear_n, p2_enable, p1_enable, time_left);
    end
    submit_p2(1'b1);
    checks++;
    if ({phase, score1, score2} !== {3'd4, 4'd0, 4'd1}) begin
      errors++;
      $display("FAIL p2_correct_score got ph=%0d s=%0d/%0d expected 4 0/1",
               phase, score1, score2);
    end
    pulse_tick(1);
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL result_hold got ph=%0d expected 4", phase);
    end
    pulse_tick(1);
    checks++;
    if ({phase, round, time_left} !== {3'd1, 4'd2, 8'd30}) begin
      errors++;
      $display("FAIL next_round got ph=%0d rnd=%0d t=%0d expected 1 2 30",
               phase, round, time_left);
    end
  endtask

  task automatic test_p2_timeout;
    press_p1;
    cyc(1);
    pulse_tick(29);
    checks++;
    if ({phase, time_left} !== {3'd3, 8'd1}) begin
      errors++;
      $display("FAIL p2_countdown got ph=%0d t=%0d expected 3 1", phase, time_left);
    end
    pulse_tick(1);
    checks++;
    if ({phase, time_left, score1, score2} !== {3'd4, 8'd0, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL p2_expiry got ph=%0d t=%0d s=%0d/%0d expected 4 0 1/1",
               phase, time_left, score1, score2);
    end
    pulse_tick(2);
    checks++;
    if ({phase, round, time_left} !== {3'd1, 4'd3, 8'd30}) begin
      errors++;
      $display("FAIL round3_start got ph=%0d rnd=%0d t=%0d expected 1 3 30",
               phase, round, time_left);
    end
  endtask

  task automatic test_simultaneous;
    pulse_tick(29);
    checks++;
    if (time_left !== 8'd1) begin
      errors++;
      $display("FAIL p1_countdown got %0d expected 1", time_left);
    end
    @(negedge clock); tick = 1'b1; p1_done = 1'b1;
    @(negedge clock); tick = 1'b0; p1_done = 1'b0;
    checks++;
    if ({phase, score1, score2} !== {3'd2, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL done_beats_expiry got ph=%0d s=%0d/%0d expected 2 1/1",
               phase, score1, score2);
    end
    cyc(1);
    submit_p2(1'b1);
    pulse_tick(2);
    checks++;
    if ({phase, round, score1, score2, winner} !== {3'd5, 4'd3, 4'd1, 4'd2, 2'b10}) begin
      errors++;
      $display("FAIL game_over_p2 got ph=%0d rnd=%0d s=%0d/%0d w=%b expected 5 3 1/2 10",
               phase, round, score1, score2, winner);
    end
  endtask

  task automatic test_held_p1;
    press_start;
    checks++;
    if ({phase, round, score1, score2, winner} !== {3'd1, 4'd1, 4'd0, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL restart_from_game_over got ph=%0d rnd=%0d s=%0d/%0d w=%b expected 1 1 0/0 00",
               phase, round, score1, score2, winner);
    end
    @(negedge clock); p1_done = 1'b1;
    @(negedge clock);
    cyc(1);
    submit_p2(1'b0);
    checks++;
    if ({phase, score1, score2} !== {3'd4, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL p2_wrong_score got ph=%0d s=%0d/%0d expected 4 1/0", phase, score1, score2);
    end
    pulse_tick(2);
    cyc(3);
    checks++;
    if ({phase, round} !== {3'd1, 4'd2}) begin
      errors++;
      $display("FAIL held_p1_round2 got ph=%0d rnd=%0d expected 1 2", phase, round);
    end
    pulse_tick(30);
    checks++;
    if ({phase, time_left, score1, score2} !== {3'd4, 8'd0, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL p1_expiry got ph=%0d t=%0d s=%0d/%0d expected 4 0 1/1",
               phase, time_left, score1, score2);
    end
    pulse_tick(2);
    cyc(2);
    checks++;
    if ({phase, round} !== {3'd1, 4'd3}) begin
      errors++;
      $display("FAIL held_p1_round3 got ph=%0d rnd=%0d expected 1 3", phase, round);
    end
    press_start;
    checks++;
    if ({phase, round, score1, score2} !== {3'd1, 4'd3, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL start_ignored_midgame got ph=%0d rnd=%0d s=%0d/%0d expected 1 3 1/1",
               phase, round, score1, score2);
    end
    p1_done = 1'b0;
    cyc(1);
  endtask

  task automatic test_tie;
    do_reset;
    press_start;
    checks++;
    if ({d2_phase, d2_round, d2_time_left} !== {3'd1, 4'd1, 8'd4}) begin
      errors++;
      $display("FAIL dut2_start got ph=%0d rnd=%0d t=%0d expected 1 1 4",
               d2_phase, d2_round, d2_time_left);
    end
    press_p1; cyc(1); submit_p2(1'b1);
    pulse_tick(1);
    press_p1; cyc(1); submit_p2(1'b0);
    pulse_tick(1);
`ifdef ROUND_SEQUENCER_SUDDEN_DEATH_EN
    checks++;
    if ({d2_phase, d2_round, d2_score1, d2_score2, d2_winner}
        !== {3'd1, 4'd3, 4'd1, 4'd1, 2'b00}) begin
      errors++;
      $display("FAIL sudden_death_entry got ph=%0d rnd=%0d s=%0d/%0d w=%b expected 1 3 1/1 00",
               d2_phase, d2_round, d2_score1, d2_score2, d2_winner);
    end
    press_p1; cyc(1); submit_p2(1'b1);
    pulse_tick(1);
    checks++;
    if ({d2_phase, d2_score1, d2_score2, d2_winner} !== {3'd5, 4'd1, 4'd2, 2'b10}) begin
      errors++;
      $display("FAIL sudden_death_end got ph=%0d s=%0d/%0d w=%b expected 5 1/2 10",
               d2_phase, d2_score1, d2_score2, d2_winner);
    end
`else
    checks++;
    if ({d2_phase, d2_round, d2_score1, d2_score2, d2_winner}
        !== {3'd5, 4'd2, 4'd1, 4'd1, 2'b11}) begin
      errors++;
      $display("FAIL tie_winner got ph=%0d rnd=%0d s=%0d/%0d w=%b expected 5 2 1/1 11",
               d2_phase, d2_round, d2_score1, d2_score2, d2_winner);
    end
`endif
  endtask

  task automatic test_async_reset;
    do_reset;
    press_start;
    press_p1;
    cyc(1);
    pulse_tick(3);
    checks++;
    if ({phase, time_left, p2_enable} !== {3'd3, 8'd27, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_p2_turn got ph=%0d t=%0d en2=%b expected 3 27 1",
               phase, time_left, p2_enable);
    end
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({p1_enable, p2_enable, p2_clear_n, phase, time_left, round, score1, score2, winner}
        !== RstVec) begin
      errors++;
      $display("FAIL async_reset got %h expected %h",
               {p1_enable, p2_enable, p2_clear_n, phase, time_left, round, score1, score2,
                winner}, RstVec);
    end
    @(negedge clock);
    resetn = 1'b1;
    cyc(1);
  endtask

  initial begin
    test_reset;
    test_start;
    test_round_correct;
    test_p2_timeout;
    test_simultaneous;
    test_held_p1;
    test_tie;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
